alu_issue_stage: RTL and testbench

Decode-to-execute issue stage that sits directly upstream of the RV32I ALU. It accepts an instruction word, PC and register-file operands over a valid/ready handshake, and decodes OP, OP-IMM, LUI and AUIPC into the ALU control encoding (func, sub_sra, shamt) and its A/B operands. Results are buffered in a small FIFO so the execute stage can stall without a combinational ready path back to decode. It also carries the destination register, write-enable and illegal flag downstream, and supports a pipeline flush.

---
 rtl/alu_issue_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue stage in front of the RV32I ALU. Decodes OP / OP-IMM / LUI / AUIPC
//   into ALU controls and operands, then buffers the result in a DEPTH-entry
//   FIFO so execute can stall without a combinational ready path to decode.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = count < DEPTH)
//   instr, pc             instruction word and address
//   rs1_data, rs2_data    register-file operands
//   flush                 drop all buffered entries and any same-cycle input
//   out_valid / out_ready downstream handshake (out_valid = count != 0)
//   alu_a, alu_b          ALU operands
//   alu_shamt             immediate shift amount
//   alu_sub_sra           subtract / arithmetic shift select
//   alu_func              ALU function code
//   rd, rd_we             destination register and write enable
//   illegal               instruction outside the supported set
module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic        alu_sub_sra,
    output logic [3:0]  alu_func,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic        sub_sra;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } entry_t;

    // ---------------- decode ----------------
    entry_t      dec;
    logic        legal;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.a = rs1_data;
                dec.b = rs2_data;
                legal = (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                case (f3)
                    3'b000: begin dec.func = 4'b0000; dec.sub_sra = f7[5]; end
                    3'b001: begin dec.func = 4'b0101; dec.b = {27'b0, rs2_data[4:0]}; end
                    3'b010: dec.func = 4'b1000;
                    3'b011: dec.func = 4'b1001;
                    3'b100: dec.func = 4'b0001;
                    3'b101: begin
                        dec.func    = 4'b0110;
                        dec.sub_sra = f7[5];
                        dec.b       = {27'b0, rs2_data[4:0]};
                    end
                    3'b110: dec.func = 4'b0010;
                    default: dec.func = 4'b0011;
                endcase
            end
            7'b0010011: begin
                dec.a = rs1_data;
                dec.b = imm_i;
                legal = 1'b1;
                case (f3)
                    3'b000: dec.func = 4'b0000;
                    3'b001: begin
                        dec.func  = 4'b0100;
                        dec.shamt = instr[24:20];
                        legal     = (f7 == 7'b0000000);
                    end
                    3'b010: dec.func = 4'b1000;
                    3'b011: dec.func = 4'b1001;
                    3'b100: dec.func = 4'b0001;
                    3'b101: begin
                        dec.func    = 4'b0111;
                        dec.shamt   = instr[24:20];
                        dec.sub_sra = instr[30];
                        legal       = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                    3'b110: dec.func = 4'b0010;
                    default: dec.func = 4'b0011;
                endcase
            end
            7'b0110111: begin
                dec.b = imm_u;
                legal = 1'b1;
            end
            7'b0010111: begin
                dec.a = pc;
                dec.b = imm_u;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings reach execute as a harmless ADD 0+0 with no writeback.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.rd    = instr[11:7];
        dec.rd_we = legal && (instr[11:7] != 5'd0);
    end

    // ---------------- FIFO ----------------
    entry_t          mem [DEPTH];
    entry_t          head, head_n;
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]   count, count_rem, count_n;
    logic            push, pop;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);

    always_comb begin
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        count_rem = pop ? count - CW'(1) : count;
        count_n   = push ? count_rem + CW'(1) : count_rem;
        rd_ptr_n  = pop ? rd_ptr + PW'(1) : rd_ptr;
        // The output register tracks the next head; when the FIFO goes
        // empty it keeps its previous contents. A push into an otherwise
        // empty FIFO is forwarded straight from decode.
        head_n    = head;
        if (count_n != '0)
            head_n = (push && count_rem == '0) ? dec : mem[rd_ptr_n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            head   <= head_n;
        end
    end

    assign alu_a       = head.a;
    assign alu_b       = head.b;
    assign alu_shamt   = head.shamt;
    assign alu_sub_sra = head.sub_sra;
    assign alu_func    = head.func;
    assign rd          = head.rd;
    assign rd_we       = head.rd_we;
    assign illegal     = head.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
    logic [31:0] instr = 0, pc = 0, rs1_data = 0, rs2_data = 0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt, rd;
    logic        alu_sub_sra, rd_we, illegal;
    logic [3:0]  alu_func;

    alu_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_sub_sra(alu_sub_sra), .alu_func(alu_func), .rd(rd),
        .rd_we(rd_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic        sub;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr, pc, rs1, rs2;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t cur();
        exp_t r;
        r = '{alu_a, alu_b, alu_shamt, alu_sub_sra, alu_func, rd, rd_we, illegal};
        return r;
    endfunction

    // Reference decode: instruction-class tables rather than per-encoding logic.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0] rfn [8];
        logic [3:0] ifn [8];
        exp_t e;
        int   f3, f7, opc;
        bit   ok, shift;
        rfn = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd1, 4'd6, 4'd2, 4'd3};
        ifn = '{4'd0, 4'd4, 4'd8, 4'd9, 4'd1, 4'd7, 4'd2, 4'd3};
        opc = int'(i[6:0]);  f3 = int'(i[14:12]);  f7 = int'(i[31:25]);
        e = '0;
        ok = 1;
        shift = (f3 == 1 || f3 == 5);
        if (opc == 'h33) begin
            ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            e.a = r1;
            e.b = shift ? r2 % 32 : r2;
            e.func = rfn[f3];
            e.sub = (f3 == 0 || f3 == 5) && f7 == 'h20;
        end else if (opc == 'h13) begin
            e.a = r1;
            e.b = 32'($signed(i) >>> 20);
            e.func = ifn[f3];
            if (shift) e.shamt = i[24:20];
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) begin
                ok = (f7 == 0) || (f7 == 'h20);
                e.sub = (f7 == 'h20);
            end
        end else if (opc == 'h37) begin
            e.b = i & 32'hFFFFF000;
        end else if (opc == 'h17) begin
            e.a = p;
            e.b = i & 32'hFFFFF000;
        end else ok = 0;
        if (!ok) begin
            e = '0;
            e.ill = 1;
        end
        e.rd = i[11:7];
        e.we = ok && (i[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op, f7;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1: op = 7'h33;
            2, 3: op = 7'h13;
            4: op = $urandom_range(0, 1) ? 7'h37 : 7'h17;
            default: op = 7'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
        else f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return {f7, r[24:7], op};
    endfunction

    function automatic logic [31:0] addi_rd(input logic [4:0] d);
        return {12'd0, 5'd0, 3'b000, d, 7'b0010011};
    endfunction

    vec_t vt [12];
    exp_t q[$];
    exp_t last, nx;
    bit   acc, pp;

    initial begin
        vt[0]  = '{"sub",       32'h402080B3, 0, 5, 7,            '{32'd5, 32'd7, 5'd0, 1'b1, 4'd0, 5'd1, 1'b1, 1'b0}};
        vt[1]  = '{"srai",      32'h4040D113, 0, 32'h80000000, 0, '{32'h80000000, 32'h404, 5'd4, 1'b1, 4'd7, 5'd2, 1'b1, 1'b0}};
        vt[2]  = '{"sra_reg",   32'h4020D1B3, 0, 32'h1234, 32'hFFFFFF23, '{32'h1234, 32'd3, 5'd0, 1'b1, 4'd6, 5'd3, 1'b1, 1'b0}};
        vt[3]  = '{"addi_x0",   32'h00000013, 0, 9, 0,            '{32'd9, 32'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0}};
        vt[4]  = '{"bad_op",    32'h0000007F, 0, 3, 4,            '{32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1}};
        vt[5]  = '{"auipc",     32'h00001097, 32'h100, 1, 2,      '{32'h100, 32'h1000, 5'd0, 1'b0, 4'd0, 5'd1, 1'b1, 1'b0}};
        vt[6]  = '{"lui",       32'hABCDE2B7, 32'h40, 1, 2,       '{32'd0, 32'hABCDE000, 5'd0, 1'b0, 4'd0, 5'd5, 1'b1, 1'b0}};
        vt[7]  = '{"sltiu_m1",  32'hFFF13093, 0, 2, 0,            '{32'd2, 32'hFFFFFFFF, 5'd0, 1'b0, 4'd9, 5'd1, 1'b1, 1'b0}};
        vt[8]  = '{"mul_ill",   32'h022081B3, 0, 6, 7,            '{32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 5'd3, 1'b0, 1'b1}};
        vt[9]  = '{"slli_ill",  32'h40109093, 0, 6, 7,            '{32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 5'd1, 1'b0, 1'b1}};
        vt[10] = '{"sll_mask",  32'h002090B3, 0, 8, 32'h25,       '{32'd8, 32'd5, 5'd0, 1'b0, 4'd5, 5'd1, 1'b1, 1'b0}};
        vt[11] = '{"and",       32'h003170B3, 0, 32'hF0F0, 32'hFF00, '{32'hF0F0, 32'hFF00, 5'd0, 1'b0, 4'd3, 5'd1, 1'b1, 1'b0}};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", cur(), '0);
        rst_n = 1;

        // table: push one vector, check it one edge later, then pop it
        foreach (vt[k]) begin
            @(posedge clk); #1;
            instr = vt[k].instr; pc = vt[k].pc; rs1_data = vt[k].rs1; rs2_data = vt[k].rs2;
            in_valid = 1;
            @(posedge clk); #1;
            in_valid = 0;
            chk({vt[k].name, "_valid"}, out_valid, 1);
            chk(vt[k].name, cur(), vt[k].e);
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
            chk({vt[k].name, "_drain"}, out_valid, 0);
            chk({vt[k].name, "_hold"}, cur(), vt[k].e);
        end

        // backpressure: three back-to-back inputs with execute stalled
        in_valid = 1; instr = addi_rd(5'd1);
        @(posedge clk); #1; instr = addi_rd(5'd2);
        @(posedge clk); #1; instr = addi_rd(5'd3);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head1", rd, 5'd1);
        @(posedge clk); #1;
        chk("bp_still_full", in_ready, 0);
        chk("bp_head1_held", rd, 5'd1);
        out_ready = 1;
        @(posedge clk); #1;          // pop 1, no push at full
        chk("bp_head2", rd, 5'd2);
        chk("bp_ready_after_pop", in_ready, 1);
        @(posedge clk); #1;          // pop 2, push 3
        in_valid = 0;
        chk("bp_head3", rd, 5'd3);
        chk("bp_valid3", out_valid, 1);
        @(posedge clk); #1;          // pop 3
        out_ready = 0;
        chk("bp_empty", out_valid, 0);

        // flush with two entries and a same-cycle input
        in_valid = 1; instr = addi_rd(5'd7);
        @(posedge clk); #1; instr = addi_rd(5'd8);
        @(posedge clk); #1; instr = addi_rd(5'd9); flush = 1;
        chk("fl_pre_count", in_ready, 0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("fl_no_output", out_valid, 0);

        // asynchronous reset between edges
        in_valid = 1; instr = 32'h003170B3; rs1_data = 32'hDEAD; rs2_data = 32'hBEEF;
        @(posedge clk); #1;
        in_valid = 0;
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_outputs", cur(), '0);
        chk("ar_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        instr = 32'h00001097; pc = 32'h100; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("ar_auipc_a", alu_a, 32'h100);
        chk("ar_auipc_b", alu_b, 32'h1000);

        // randomized traffic against a queue model
        rst_n = 0; #1; rst_n = 1;
        q.delete();
        last = '0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 40) == 0;
            instr     = rand_instr();
            pc        = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            acc = in_valid && q.size() < DEPTH && !flush;
            pp  = q.size() != 0 && out_ready && !flush;
            nx  = model(instr, pc, rs1_data, rs2_data);
            @(posedge clk); #1;
            if (flush) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(nx);
            end
            if (q.size() != 0) last = q[0];
            chk("rnd_out_valid", out_valid, q.size() != 0);
            chk("rnd_in_ready", in_ready, q.size() < DEPTH);
            chk("rnd_data", cur(), last);
        end
        in_valid = 0; flush = 0; out_ready = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
